rr_arb_b2oh: RTL

//  Round-robin arbiter sharing one resource among 2**N requesters. Tracks the

---
 rtl/rr_arb_b2oh_pkg.sv | 14 +
 rtl/rr_arb_b2oh_b2oh.sv | 17 +
 rtl/rr_arb_b2oh.sv | 101 ++++++++++
 3 files changed

// File: rtl/rr_arb_b2oh_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rr_arb_b2oh_pkg;

  localparam int DEF_N        = 3;
  localparam int DEF_HOLD_MAX = 15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb_b2oh_b2oh.sv
// Binary index to one-hot decoder.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of bin.
// Ports: bin (N-bit binary index) -> oh (2**N-bit one-hot vector).
module b2oh #(
  parameter int N = 3
) (
  input  logic [N-1:0]      bin,
  output logic [2**N-1:0]   oh
);

  always_comb begin
    oh      = '0;
    oh[bin] = 1'b1;
  end

endmodule

// File: rtl/rr_arb_b2oh.sv
// Round-robin arbiter granting one of 2**N requesters, with forced release after HOLD_MAX cycles.
// Latency: req sampled on edge k -> grant visible after edge k; every release spends one cycle in IDLE.
// Backpressure: owner holds the grant until done, req withdrawal, or hold expiry (timeout pulse).
// Ports: clk, rst_n (async active-low); req[2**N], done in;
//        grant[2**N] one-hot, grant_idx[N], grant_valid, timeout (1-cycle pulse) out.
module rr_arb_b2oh
  import rr_arb_b2oh_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2**N-1:0]   req,
  input  logic              done,
  output logic [2**N-1:0]   grant,
  output logic [N-1:0]      grant_idx,
  output logic              grant_valid,
  output logic              timeout
);

  localparam int NR = 2**N;
  localparam int CW = $clog2(HOLD_MAX + 1);

  state_t          state;
  logic [N-1:0]    ptr;
  logic [CW-1:0]   cnt;

  logic            win_vld;
  logic [N-1:0]    win_idx;
  logic [N-1:0]    scan_idx;
  logic            owner_req;
  logic            hold_exp;
  logic            release_now;
  logic [NR-1:0]   idx_oh;

  // Priority scan starting at ptr. Offsets are visited from the far end
  // toward 0 so the last hit (smallest offset from ptr) wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = ptr;
    scan_idx = ptr;
    for (int k = NR - 1; k >= 0; k--) begin
      scan_idx = ptr + N'(k);
      if (req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  assign owner_req   = req[grant_idx];
  assign hold_exp    = (cnt == CW'(HOLD_MAX - 1));
  assign release_now = done || !owner_req || hold_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            grant_idx   <= win_idx;
            grant_valid <= 1'b1;
            cnt         <= '0;
            state       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            grant_valid <= 1'b0;
            ptr         <= grant_idx + N'(1);
            cnt         <= '0;
            // Only a pure expiry counts as a timeout; a done or withdrawal
            // on the same edge is a normal release.
            timeout     <= hold_exp && !done && owner_req;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  b2oh #(.N(N)) u_b2oh (
    .bin (grant_idx),
    .oh  (idx_oh)
  );

  // Gating with the registered valid keeps grant purely a function of state.
  assign grant = idx_oh & {NR{grant_valid}};

endmodule
